// File: rtl/conv_frame_collector_if.sv
// Bundles the pixel stream, frame handshake, read port and status of the frame collector.
interface conv_frame_collector_if #(
  parameter int AW = 16
);
  logic [7:0]    pxl_in;
  logic          pxl_valid;
  logic          frame_ack;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic          rd_valid;
  logic [AW-1:0] col;
  logic [AW-1:0] row;
  logic [AW-1:0] pxl_count;
  logic          busy;
  logic          frame_done;
  logic          overflow;

  modport slave (
    input  pxl_in, pxl_valid, frame_ack, rd_en, rd_addr,
    output rd_data, rd_valid, col, row, pxl_count, busy, frame_done, overflow
  );

  modport master (
    output pxl_in, pxl_valid, frame_ack, rd_en, rd_addr,
    input  rd_data, rd_valid, col, row, pxl_count, busy, frame_done, overflow
  );
endinterface

// File: rtl/conv_frame_collector.sv
// Captures one frame of the 1xK convolution output stream into a raster-ordered buffer
// and serves it through a registered random-access read port.
module conv_frame_collector #(
  parameter int W  = 220,
  parameter int H  = 220,
  parameter int K  = 7,
  parameter int AW = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  conv_frame_collector_if.slave  bus
);

  localparam int OW    = W - K + 1;
  localparam int DEPTH = OW * H;
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] OW_LAST = AW'(OW - 1);
  localparam logic [AW-1:0] H_LAST  = AW'(H - 1);
  localparam logic [AW-1:0] ONE     = AW'(1);

  typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] col_q, col_d;
  logic [AW-1:0] row_q, row_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic [7:0]    rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;

  logic [7:0]    mem_q [DEPTH];
  logic          wr_en;
  logic [IW-1:0] wr_addr;

  logic          take;
  logic [AW-1:0] base_cnt, base_col, base_row;
  logic          rd_in_range;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    col_d    = col_q;
    row_d    = row_q;
    ovf_d    = ovf_q;
    take     = 1'b0;
    base_cnt = cnt_q;
    base_col = col_q;
    base_row = row_q;
    wr_en    = 1'b0;
    wr_addr  = cnt_q[IW-1:0];

    unique case (state_q)
      IDLE, COLLECT: take = bus.pxl_valid;
      DONE: begin
        if (bus.frame_ack) begin
          // Ack re-arms from zero; a pixel in the same cycle starts the next frame.
          state_d  = IDLE;
          cnt_d    = '0;
          col_d    = '0;
          row_d    = '0;
          base_cnt = '0;
          base_col = '0;
          base_row = '0;
          take     = bus.pxl_valid;
        end else if (bus.pxl_valid) begin
          ovf_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      wr_en   = 1'b1;
      wr_addr = base_cnt[IW-1:0];
      cnt_d   = base_cnt + ONE;
      state_d = COLLECT;
      if (base_col == OW_LAST) begin
        col_d = '0;
        if (base_row == H_LAST) begin
          row_d   = '0;
          state_d = DONE;
        end else begin
          row_d = base_row + ONE;
        end
      end else begin
        col_d = base_col + ONE;
      end
    end
  end

  assign rd_in_range = 32'(bus.rd_addr) < DEPTH;

  always_comb begin
    rd_valid_d = bus.rd_en;
    rd_data_d  = rd_data_q;
    if (bus.rd_en) begin
      rd_data_d = rd_in_range ? mem_q[bus.rd_addr[IW-1:0]] : 8'h00;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      rd_data_q  <= 8'h00;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Buffer has no reset; reads sample the pre-edge contents, giving read-before-write.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= bus.pxl_in;
  end

  assign bus.rd_data    = rd_data_q;
  assign bus.rd_valid   = rd_valid_q;
  assign bus.col        = col_q;
  assign bus.row        = row_q;
  assign bus.pxl_count  = cnt_q;
  assign bus.busy       = (state_q == COLLECT);
  assign bus.frame_done = (state_q == DONE);
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_conv_frame_collector.sv
// Directed bench for conv_frame_collector with a 4x4 output frame (W=10, H=4, K=7).
module tb_conv_frame_collector;

  localparam int W  = 10;
  localparam int H  = 4;
  localparam int K  = 7;
  localparam int AW = 8;

  logic clk;
  logic reset;
  int   vectors;
  int   miscompares;

  conv_frame_collector_if #(.AW(AW)) bus ();

  conv_frame_collector #(.W(W), .H(H), .K(K), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_col"},  32'(bus.col), 0);
    chk({tag, "_row"},  32'(bus.row), 0);
    chk({tag, "_cnt"},  32'(bus.pxl_count), 0);
    chk({tag, "_rdd"},  32'(bus.rd_data), 0);
    chk({tag, "_rdv"},  32'(bus.rd_valid), 0);
    chk({tag, "_busy"}, 32'(bus.busy), 0);
    chk({tag, "_done"}, 32'(bus.frame_done), 0);
    chk({tag, "_ovf"},  32'(bus.overflow), 0);
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    reset         = 1'b0;
    bus.pxl_in    = 8'h00;
    bus.pxl_valid = 1'b0;
    bus.frame_ack = 1'b0;
    bus.rd_en     = 1'b0;
    bus.rd_addr   = '0;

    #12;
    chk_all_zero("rst");
    reset = 1'b1;

    // Test 1: 16 pixels with gaps after pixels 3 and 9
    for (int i = 0; i < 16; i++) begin
      bus.pxl_valid = 1'b1;
      bus.pxl_in    = 8'(i);
      tick();
      chk("t1_busy", 32'(bus.busy), 32'(i < 15));
      chk("t1_done", 32'(bus.frame_done), 32'(i == 15));
      chk("t1_cnt",  32'(bus.pxl_count), 32'(i + 1));
      if (i == 3 || i == 9) begin
        bus.pxl_valid = 1'b0;
        tick();
        chk("t1_gap_cnt", 32'(bus.pxl_count), 32'(i + 1));
        chk("t1_gap_row", 32'(bus.row), 32'((i + 1) / 4));
        chk("t1_gap_col", 32'(bus.col), 32'((i + 1) % 4));
      end
    end
    bus.pxl_valid = 1'b0;
    chk("t1_row", 32'(bus.row), 0);
    chk("t1_col", 32'(bus.col), 0);

    // Test 2: reads including one past the end
    bus.rd_en = 1'b1;
    bus.rd_addr = 8'd0;  tick();
    chk("t2_v0", 32'(bus.rd_valid), 1); chk("t2_d0", 32'(bus.rd_data), 32'h00);
    bus.rd_addr = 8'd5;  tick();
    chk("t2_v5", 32'(bus.rd_valid), 1); chk("t2_d5", 32'(bus.rd_data), 32'h05);
    bus.rd_addr = 8'd15; tick();
    chk("t2_v15", 32'(bus.rd_valid), 1); chk("t2_d15", 32'(bus.rd_data), 32'h0F);
    bus.rd_addr = 8'd16; tick();
    chk("t2_v16", 32'(bus.rd_valid), 1); chk("t2_d16", 32'(bus.rd_data), 32'h00);
    bus.rd_en = 1'b0; tick();
    chk("t2_vidle", 32'(bus.rd_valid), 0);

    // Test 3: pixel in DONE without ack is dropped
    bus.pxl_valid = 1'b1; bus.pxl_in = 8'hAA; tick();
    bus.pxl_valid = 1'b0;
    chk("t3_ovf",  32'(bus.overflow), 1);
    chk("t3_cnt",  32'(bus.pxl_count), 16);
    chk("t3_done", 32'(bus.frame_done), 1);
    bus.rd_en = 1'b1; bus.rd_addr = 8'd0; tick();
    bus.rd_en = 1'b0;
    chk("t3_mem0", 32'(bus.rd_data), 32'h00);

    // Test 4: ack and pixel in the same cycle
    bus.frame_ack = 1'b1; bus.pxl_valid = 1'b1; bus.pxl_in = 8'h55; tick();
    bus.frame_ack = 1'b0; bus.pxl_valid = 1'b0;
    chk("t4_busy", 32'(bus.busy), 1);
    chk("t4_cnt",  32'(bus.pxl_count), 1);
    chk("t4_col",  32'(bus.col), 1);
    chk("t4_ovf",  32'(bus.overflow), 1);
    bus.rd_en = 1'b1; bus.rd_addr = 8'd0; tick();
    bus.rd_en = 1'b0;
    chk("t4_mem0", 32'(bus.rd_data), 32'h55);
    tick();
    chk("t4_hold_d", 32'(bus.rd_data), 32'h55);
    chk("t4_hold_v", 32'(bus.rd_valid), 0);
    bus.frame_ack = 1'b1; tick();
    bus.frame_ack = 1'b0;
    chk("t4_ack_busy", 32'(bus.busy), 1);
    chk("t4_ack_cnt",  32'(bus.pxl_count), 1);

    // Test 5: asynchronous reset mid-frame at pxl_count=7
    for (int i = 1; i < 7; i++) begin
      bus.pxl_valid = 1'b1; bus.pxl_in = 8'(100 + i); tick();
    end
    bus.pxl_valid = 1'b0;
    chk("t5_pre_cnt", 32'(bus.pxl_count), 7);
    #3 reset = 1'b0;
    #1 chk_all_zero("t5_rst");
    #2 reset = 1'b1;
    for (int i = 0; i < 16; i++) begin
      bus.pxl_valid = 1'b1; bus.pxl_in = 8'(i * 3 + 1); tick();
      chk("t5_done", 32'(bus.frame_done), 32'(i == 15));
    end
    bus.pxl_valid = 1'b0;
    bus.rd_en = 1'b1; bus.rd_addr = 8'd7; tick();
    chk("t5_mem7", 32'(bus.rd_data), 32'd22);
    bus.rd_addr = 8'd15; tick();
    bus.rd_en = 1'b0;
    chk("t5_mem15", 32'(bus.rd_data), 32'd46);

    // Test 6: ack to IDLE, then 16 back-to-back pixels
    bus.frame_ack = 1'b1; tick();
    bus.frame_ack = 1'b0;
    chk("t6_idle_busy", 32'(bus.busy), 0);
    chk("t6_idle_done", 32'(bus.frame_done), 0);
    chk("t6_idle_cnt",  32'(bus.pxl_count), 0);
    chk("t6_idle_ovf",  32'(bus.overflow), 0);
    for (int j = 1; j <= 16; j++) begin
      bus.pxl_valid = 1'b1; bus.pxl_in = 8'(200 + j); tick();
      chk("t6_cnt",  32'(bus.pxl_count), 32'(j));
      chk("t6_col",  32'(bus.col), 32'(j % 4));
      chk("t6_row",  32'(bus.row), (j == 16) ? 32'd0 : 32'(j / 4));
      chk("t6_done", 32'(bus.frame_done), 32'(j == 16));
    end
    bus.frame_ack = 1'b1; bus.pxl_valid = 1'b1; bus.pxl_in = 8'h33; tick();
    bus.frame_ack = 1'b0; bus.pxl_valid = 1'b0;
    chk("t6_rearm_cnt", 32'(bus.pxl_count), 1);
    chk("t6_rearm_ovf", 32'(bus.overflow), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
